// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with overlapping/non-overlapping modes.
// Optional saturating match counter is built only when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             c,
  input  logic             en,
  input  logic             ovl,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] cnt
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  typedef enum logic {FILL, ARMED} state_t;

  state_t           state_q, state_nx;
  logic [PAT_W-1:0] hist_q, hist_nx, hist_sh;
  logic [FW-1:0]    fill_q, fill_nx, fill_sh;
  logic [PAT_W:0]   hist_ext;
  logic             match;

  // Post-shift view; only committed on enabled edges.
  always_comb begin
    hist_ext = {hist_q, c};
    hist_sh  = hist_ext[PAT_W-1:0];
    fill_sh  = (state_q == ARMED) ? fill_q : fill_q + FW'(1);
    match    = en && (fill_sh == FULL) && (hist_sh == PATTERN);
  end

  always_comb begin
    state_nx = state_q;
    hist_nx  = hist_q;
    fill_nx  = fill_q;
    if (en) begin
      hist_nx = hist_sh;
      if (match && !ovl) begin
        // Drop every consumed bit so none is shared with the next match.
        fill_nx  = '0;
        state_nx = FILL;
      end else begin
        fill_nx  = fill_sh;
        state_nx = (fill_sh == FULL) ? ARMED : FILL;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rs) begin
      state_q <= FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      y       <= 1'b0;
    end else begin
      state_q <= state_nx;
      hist_q  <= hist_nx;
      fill_q  <= fill_nx;
      y       <= match;
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Clear wins over a coincident match; y still reports that match.
  always_ff @(posedge ck) begin
    if (rs)                          cnt_q <= '0;
    else if (clr)                    cnt_q <= '0;
    else if (match && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign cnt = '0;
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL expose parameter PAT_W, default 4: detected pattern length in bits; legal range 1..32.
REQ-002 SHALL expose parameter PATTERN, default 4'b1011 (PAT_W bits): target sequence; MSB is the oldest bit received.
REQ-003 SHALL expose parameter CNT_W, default 8: match-counter width; legal range 1..32.
REQ-004 SHALL have port ck  input  1  single clock; all state changes on the rising edge only.
REQ-005 SHALL have port rs  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port c  input  1  serial data bit.
REQ-007 SHALL have port en  input  1  sample enable; c is consumed only on edges where en=1.
REQ-008 SHALL have port ovl  input  1  mode select: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port clr  input  1  synchronous clear of the match counter only.
REQ-010 SHALL have port y  output  1  registered match pulse.
REQ-011 SHALL have port cnt  output  CNT_W  saturating match count.

Function
REQ-012 SHALL hold a PAT_W-bit history register and a fill counter (0..PAT_W) of valid bits received.
REQ-013 SHALL implement two states: FILL (fill<PAT_W) and ARMED (fill==PAT_W).
REQ-014 On an edge with en=1, SHALL shift c into the history LSB and increment fill, saturating at PAT_W; FILL->ARMED when fill reaches PAT_W.
REQ-015 On an edge with en=1, SHALL declare a match when the post-shift fill equals PAT_W and the post-shift history equals PATTERN.
REQ-016 On every edge, SHALL set y to the match result of that edge, so y is high for exactly one cycle per match; an edge with en=0 SHALL clear y and leave history and fill unchanged.
REQ-017 On a match with ovl=1, SHALL keep history and fill, allowing the next match to reuse trailing bits.
REQ-018 On a match with ovl=0, SHALL clear fill to 0 and return to FILL, so no received bit contributes to two matches.
REQ-019 SHALL allow ovl to change on any edge; the value sampled on the matching edge decides the REQ-017/REQ-018 behaviour.
REQ-020 On a match, SHALL increment cnt by 1, saturating at 2^CNT_W-1.
REQ-021 When clr=1 SHALL load cnt with 0 on that edge; clr SHALL take precedence over a simultaneous match, while y still pulses for that match.
REQ-022 With PAT_W=1, SHALL report a match on every enabled edge where c equals PATTERN[0].

Reset
REQ-023 When rs=1 on an edge, SHALL clear history, fill, y and cnt to 0 and enter FILL, regardless of en, clr or c.
REQ-024 SHALL ignore bits received before a mid-stream reset; detection restarts from an empty history.

Configuration
REQ-025 The macro SEQ_DETECT_CNT_EN SHALL control counter inclusion: when defined, cnt behaves per REQ-020/REQ-021; when undefined, no counter register is built, cnt is constant 0, clr is ignored, and y behaviour is unchanged.

Verification (PAT_W=4, PATTERN=1011, CNT_W=8, SEQ_DETECT_CNT_EN defined unless stated)
REQ-026 ovl=1, en=1, c=1,0,1,1,0,1,1 -> y pulses one cycle after bits 4 and 7; cnt=2.
REQ-027 ovl=0, same stream as REQ-026 -> y pulses only after bit 4; cnt=1.
REQ-028 ovl=1, c=1,0,1 then en=0 for 3 cycles, then c=1 -> y=0 during the gap; one y pulse after the 4th enabled bit; cnt=1.
REQ-029 c=1,0,1, then rs=1 on one edge, then c=1,0,1,1 -> no match on the first 1 after reset; exactly one pulse after the final 1; cnt=1.
REQ-030 CNT_W=2, 5 non-overlapping matches -> cnt reads 1,2,3,3,3; clr asserted on the 5th match edge -> cnt=0 and y=1 that cycle.
REQ-031 SEQ_DETECT_CNT_EN undefined, stream of REQ-026 -> y identical to REQ-026; cnt=0 throughout.
